// File: rtl/uart_pkg.sv
// Shared types and rate helpers for the 8N1 UART core.
// State encodings for both directions plus the clock-divider calculation.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_ERROR
    } rx_state_e;

    localparam int RX_OVERSAMPLE = 16;

    // Integer-truncated clock cycles per (bit / oversample).
    function automatic int uart_div(input int clk_hz, input int bit_hz, input int oversample);
        return clk_hz / (bit_hz * oversample);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: rx synchroniser, 16x oversampler and frame state machine.
// Each bit is 16 ticks; the stop bit is judged at mid-bit so back-to-back frames fit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int RX_DIV = 325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       recv_error,
    output logic [3:0] rx_samples,
    output logic [3:0] rx_sample_countdown
);

    localparam int DW = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(RX_DIV - 1);

    logic            sync1_q, sync2_q;
    logic [DW-1:0]   div_q, div_d;
    rx_state_e       state_q, state_d;
    logic [3:0]      samples_q, samples_d;
    logic [3:0]      countdown_q, countdown_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            received_q, received_d;
    logic            recv_error_q, recv_error_d;

    logic            rx_sync;
    logic            tick;
    logic [3:0]      sample_sum;
    logic            bit_val;

    assign rx_sync = sync2_q;

    always_comb begin
        state_d      = state_q;
        samples_d    = samples_q;
        countdown_d  = countdown_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        received_d   = 1'b0;
        recv_error_d = 1'b0;

        tick       = (div_q == DIV_LAST);
        div_d      = tick ? '0 : div_q + 1'b1;
        sample_sum = samples_q + {3'b000, rx_sync};
        // 15 samples are counted per bit; the 16th tick only closes the bit.
        bit_val    = (samples_q >= 4'd8);

        unique case (state_q)
            RX_IDLE: begin
                if (!rx_sync) begin
                    state_d     = RX_START;
                    countdown_d = 4'd15;
                    samples_d   = 4'd0;
                    bit_cnt_d   = 3'd0;
                    div_d       = '0;
                end
            end
            RX_START, RX_DATA: begin
                if (tick) begin
                    if (countdown_q == 4'd0) begin
                        countdown_d = 4'd15;
                        samples_d   = 4'd0;
                        if (state_q == RX_START) begin
                            state_d = bit_val ? RX_IDLE : RX_DATA;
                        end else begin
                            shift_d   = {bit_val, shift_q[7:1]};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_d = RX_STOP;
                            end
                        end
                    end else begin
                        samples_d   = sample_sum;
                        countdown_d = countdown_q - 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    samples_d   = sample_sum;
                    countdown_d = countdown_q - 4'd1;
                    // Eighth tick of the stop bit: majority of 8 decides.
                    if (countdown_q == 4'd8) begin
                        if (sample_sum >= 4'd5) begin
                            rx_byte_d  = shift_q;
                            received_d = 1'b1;
                            state_d    = RX_IDLE;
                        end else begin
                            recv_error_d = 1'b1;
                            state_d      = RX_ERROR;
                        end
                    end
                end
            end
            RX_ERROR: begin
                if (rx_sync) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            div_q        <= '0;
            state_q      <= RX_IDLE;
            samples_q    <= 4'd0;
            countdown_q  <= 4'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            rx_byte_q    <= 8'd0;
            received_q   <= 1'b0;
            recv_error_q <= 1'b0;
        end else begin
            sync1_q      <= rx;
            sync2_q      <= sync1_q;
            div_q        <= div_d;
            state_q      <= state_d;
            samples_q    <= samples_d;
            countdown_q  <= countdown_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            received_q   <= received_d;
            recv_error_q <= recv_error_d;
        end
    end

    assign received            = received_q;
    assign rx_byte             = rx_byte_q;
    assign recv_error          = recv_error_q;
    assign rx_samples          = samples_q;
    assign rx_sample_countdown = countdown_q;
    assign is_receiving        = (state_q == RX_START) || (state_q == RX_DATA) ||
                                 (state_q == RX_STOP);

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: transmitter lives here, receiver in uart_rx.
// Bit timing comes from integer division of the system clock.
module uart_core
    import uart_pkg::*;
#(
    parameter int baud_rate    = 19200,
    parameter int sys_clk_freq = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       is_transmitting,
    output logic       recv_error,
    output logic [3:0] rx_samples,
    output logic [3:0] rx_sample_countdown
);

    localparam int TX_DIV = uart_div(sys_clk_freq, baud_rate, 1);
    localparam int RX_DIV = uart_div(sys_clk_freq, baud_rate, RX_OVERSAMPLE);
    localparam int TW     = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam logic [TW-1:0] TX_LAST = TW'(TX_DIV - 1);

    tx_state_e      tx_state_q, tx_state_d;
    logic [TW-1:0]  tx_div_q, tx_div_d;
    logic [2:0]     tx_bit_q, tx_bit_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_q, tx_d;
    logic           transmit_prev_q;
    logic           bit_done;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_d       = tx_q;
        bit_done   = (tx_div_q == TX_LAST);
        tx_div_d   = bit_done ? '0 : tx_div_q + 1'b1;

        unique case (tx_state_q)
            TX_IDLE: begin
                tx_d     = 1'b1;
                tx_div_d = '0;
                // Edge, not level: a held request yields a single frame.
                if (transmit && !transmit_prev_q) begin
                    tx_data_d  = tx_byte;
                    tx_state_d = TX_START;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (bit_done) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_data_q[0];
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d  = tx_bit_q + 3'd1;
                        tx_data_d = {1'b0, tx_data_q[7:1]};
                        tx_d      = tx_data_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q      <= TX_IDLE;
            tx_div_q        <= '0;
            tx_bit_q        <= 3'd0;
            tx_data_q       <= 8'd0;
            tx_q            <= 1'b1;
            transmit_prev_q <= 1'b0;
        end else begin
            tx_state_q      <= tx_state_d;
            tx_div_q        <= tx_div_d;
            tx_bit_q        <= tx_bit_d;
            tx_data_q       <= tx_data_d;
            tx_q            <= tx_d;
            transmit_prev_q <= transmit;
        end
    end

    assign tx              = tx_q;
    assign is_transmitting = (tx_state_q != TX_IDLE);

    uart_rx #(
        .RX_DIV(RX_DIV)
    ) u_rx (
        .clk                 (clk),
        .rst                 (rst),
        .rx                  (rx),
        .received            (received),
        .rx_byte             (rx_byte),
        .is_receiving        (is_receiving),
        .recv_error          (recv_error),
        .rx_samples          (rx_samples),
        .rx_sample_countdown (rx_sample_countdown)
    );

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at a scaled bit rate (160 clocks/bit, 10 per rx tick).
// Drives and samples on the falling clock edge.
module tb_uart_core;

    localparam int SYS  = 1_600_000;
    localparam int BAUD = 10_000;
    localparam int BIT  = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       transmit = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx, received, is_receiving, is_transmitting, recv_error;
    logic [7:0] rx_byte;
    logic [3:0] rx_samples, rx_sample_countdown;

    int total = 0;
    int bad   = 0;
    int rcv_cnt = 0, err_cnt = 0, it_cyc = 0, low_cyc = 0;

    uart_core #(
        .baud_rate    (BAUD),
        .sys_clk_freq (SYS)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx                  (rx),
        .tx                  (tx),
        .transmit            (transmit),
        .tx_byte             (tx_byte),
        .received            (received),
        .rx_byte             (rx_byte),
        .is_receiving        (is_receiving),
        .is_transmitting     (is_transmitting),
        .recv_error          (recv_error),
        .rx_samples          (rx_samples),
        .rx_sample_countdown (rx_sample_countdown)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (received)        rcv_cnt <= rcv_cnt + 1;
        if (recv_error)      err_cnt <= err_cnt + 1;
        if (is_transmitting) it_cyc  <= it_cyc + 1;
        if (!tx)             low_cyc <= low_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; holds the level for one bit time.
    task automatic line_bit(input logic v);
        rx = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        line_bit(stop);
        rx = 1'b1;
    endtask

    // Entered on the first falling edge after the start edge; samples at bit centres.
    task automatic tx_frame(output logic [7:0] b, output logic st, output logic sp);
        b = 8'h00;
        repeat (BIT / 2) @(negedge clk);
        st = tx;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            b[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        sp = tx;
    endtask

    initial begin
        logic [7:0] vals [3];
        logic [7:0] b;
        logic       st, sp;
        int         r0, e0, i0, l0;
        vals = '{8'h55, 8'hAA, 8'h45};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx",        32'(tx), 32'd1);
        chk("rst_received",  32'(received), 32'd0);
        chk("rst_rx_byte",   32'(rx_byte), 32'd0);
        chk("rst_is_rx",     32'(is_receiving), 32'd0);
        chk("rst_is_tx",     32'(is_transmitting), 32'd0);
        chk("rst_recv_err",  32'(recv_error), 32'd0);
        chk("rst_samples",   32'(rx_samples), 32'd0);
        chk("rst_countdown", 32'(rx_sample_countdown), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Receive three frames
        for (int i = 0; i < 3; i++) begin
            r0 = rcv_cnt;
            e0 = err_cnt;
            rx_frame(vals[i], 1'b1);
            repeat (BIT) @(negedge clk);
            chk("rx_pulses", 32'(rcv_cnt - r0), 32'd1);
            chk("rx_byte",   32'(rx_byte), 32'(vals[i]));
            chk("rx_noerr",  32'(err_cnt - e0), 32'd0);
            chk("rx_idle",   32'(is_receiving), 32'd0);
        end

        // Single-cycle transmit request
        @(negedge clk);
        tx_byte  = 8'hAA;
        transmit = 1'b1;
        i0 = it_cyc;
        @(negedge clk);
        transmit = 1'b0;
        chk("tx_start_low", 32'(tx), 32'd0);
        chk("tx_busy_rise", 32'(is_transmitting), 32'd1);
        tx_frame(b, st, sp);
        chk("tx_startbit", 32'(st), 32'd0);
        chk("tx_byte_aa",  32'(b), 32'hAA);
        chk("tx_stopbit",  32'(sp), 32'd1);
        repeat (BIT) @(negedge clk);
        chk("tx_busy_fall", 32'(is_transmitting), 32'd0);
        chk("tx_busy_len",  32'(it_cyc - i0), 32'(10 * BIT));

        // Held request: one frame only
        @(negedge clk);
        tx_byte  = 8'h55;
        transmit = 1'b1;
        l0 = low_cyc;
        @(negedge clk);
        tx_frame(b, st, sp);
        chk("held_byte", 32'(b), 32'h55);
        repeat (20 * BIT - 9 * BIT - BIT / 2) @(negedge clk);
        chk("held_tx_high",  32'(tx), 32'd1);
        chk("held_not_busy", 32'(is_transmitting), 32'd0);
        chk("held_low_cyc",  32'(low_cyc - l0), 32'(5 * BIT));
        transmit = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_tx_idle", 32'(tx), 32'd1);

        // Framing error, then recovery
        r0 = rcv_cnt;
        e0 = err_cnt;
        rx_frame(8'h3C, 1'b0);
        repeat (BIT) @(negedge clk);
        chk("ferr_pulse", 32'(err_cnt - e0), 32'd1);
        chk("ferr_norx",  32'(rcv_cnt - r0), 32'd0);
        chk("ferr_hold",  32'(rx_byte), 32'h45);
        r0 = rcv_cnt;
        rx_frame(8'h81, 1'b1);
        repeat (BIT) @(negedge clk);
        chk("ferr_next_cnt",  32'(rcv_cnt - r0), 32'd1);
        chk("ferr_next_byte", 32'(rx_byte), 32'h81);

        // False start glitch
        r0 = rcv_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_is_rx",     32'(is_receiving), 32'd1);
        chk("glitch_countdown", 32'(rx_sample_countdown), 32'd14);
        chk("glitch_samples",   32'(rx_samples), 32'd0);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("glitch_norx",  32'(rcv_cnt - r0), 32'd0);
        chk("glitch_noerr", 32'(err_cnt - e0), 32'd0);
        chk("glitch_idle",  32'(is_receiving), 32'd0);

        // Reset during transmission
        tx_byte  = 8'h3C;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        repeat (500) @(negedge clk);
        chk("abort_busy", 32'(is_transmitting), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_tx_high", 32'(tx), 32'd1);
        chk("abort_idle",    32'(is_transmitting), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tx_byte  = 8'h45;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        tx_frame(b, st, sp);
        chk("after_start", 32'(st), 32'd0);
        chk("after_byte",  32'(b), 32'h45);
        chk("after_stop",  32'(sp), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_core.md
# uart_core

Full-duplex 8N1 asynchronous serial transceiver: one start bit, 8 data bits LSB first, one stop bit, no parity. It converts a parallel byte into a serial `tx` frame and deserialises `rx` frames into `rx_byte`. It sits between a byte-oriented host interface and the board's serial pins. Bit rate is derived from the system clock by integer division.

## Interface
- `baud_rate`, default 19200: line bit rate (bits/s).
- `sys_clk_freq`, default 100000000: `clk` frequency (Hz).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `rx`  in  1  serial input; idle high.
- `tx`  out  1  serial output; idle high.
- `transmit`  in  1  transmit request; acted on at its rising edge.
- `tx_byte`  in  8  byte to send; sampled at request acceptance.
- `received`  out  1  one-cycle pulse when a valid frame completes.
- `rx_byte`  out  8  last received byte; held until the next valid frame.
- `is_receiving`  out  1  high while the receiver is inside a frame.
- `is_transmitting`  out  1  high while the transmitter is sending a frame.
- `recv_error`  out  1  one-cycle pulse on a framing error (bad stop bit).
- `rx_samples`  out  4  debug: count of high samples in the current rx bit.
- `rx_sample_countdown`  out  4  debug: rx oversample ticks remaining in the current bit.

## Operation
- Constants: TX_DIV = sys_clk_freq/baud_rate (5208 at defaults). RX_DIV = sys_clk_freq/(baud_rate*16) (325 at defaults). Both use integer truncation.
- `rx` passes through a 2-flop synchroniser before any use.
- **Transmitter states: IDLE, START, DATA, STOP.**
  - IDLE: detect a rising edge of `transmit` (high now, low the previous cycle). On detection, latch `tx_byte` and enter START.
  - A `transmit` held high starts exactly one frame.
  - Rising edges that arrive while not in IDLE are ignored.
  - START drives `tx`=0. DATA drives bit[0] through bit[7]. STOP drives `tx`=1. Each bit lasts exactly TX_DIV cycles.
  - After STOP, return to IDLE.
  - `is_transmitting` is 1 in every state except IDLE.
- **Receiver states: IDLE, START, DATA, STOP, ERROR.**
  - A tick is generated every RX_DIV cycles. The tick divider restarts when a start edge is detected.
  - IDLE: a synchronised `rx`=0 enters START. At entry, `rx_sample_countdown` is set to 15 and `rx_samples` to 0.
  - Each tick, sample `rx`, add 1 to `rx_samples` if the sample is high, and decrement `rx_sample_countdown`.
  - A bit ends when `rx_sample_countdown` reaches 0 (16 ticks). The bit value is 1 if `rx_samples` ≥ 8 (15 samples counted; the 16th tick ends the bit). The counters then reload.
  - START: a majority-high result is a false start. Return to IDLE with no error.
  - DATA: shift each bit in LSB first; move to STOP after 8 bits.
  - STOP: evaluate after 8 ticks (mid-bit). Bit is high if ≥5 of those 8 samples are high.
    - High: load `rx_byte`, pulse `received` for 1 cycle, go to IDLE.
    - Low: pulse `recv_error` for 1 cycle, go to ERROR.
  - ERROR: wait for synchronised `rx`=1, then go to IDLE.
  - `is_receiving` is 1 in START, DATA and STOP.
- Receiver and transmitter are fully independent and may run simultaneously.

## Timing
- **Reset values:** `tx`=1, `received`=0, `rx_byte`=0, `is_receiving`=0, `is_transmitting`=0, `recv_error`=0, `rx_samples`=0, `rx_sample_countdown`=0. Both state machines go to IDLE.
- **Reset mid-frame:** the frame is aborted and `tx` returns high immediately.
- **Transmit timing:**
  - `transmit` rising edge at cycle N: `tx` falls and `is_transmitting` rises at N+1.
  - Frame length is 10*TX_DIV cycles. `is_transmitting` falls after the last stop-bit cycle.
- **Receive timing:** from the `rx` falling edge, `received` pulses after 2 + (9*16+8)*RX_DIV cycles, ±RX_DIV. This is mid-stop-bit, so back-to-back frames are accepted.

## Structure
- Shared package `uart_pkg`: tx and rx state enums, and a function computing TX_DIV/RX_DIV from the parameters.
- One natural sub-module: `uart_rx`, containing the synchroniser, oversampler and receive state machine.
- The transmitter stays in the top level.

## Test plan
- **Receive:** send frames 0x55, 0xAA, 0x45 on `rx` at 5208 cycles/bit -> each gives one `received` pulse, `rx_byte` equals the sent byte, and `recv_error` stays 0.
- **Transmit:** pulse `transmit` for 1 cycle with `tx_byte`=0xAA -> bench decoder sees 0xAA, `tx` low for 5208 cycles first, and `is_transmitting` high for 52080 cycles.
- **Held request:** hold `transmit` high for 2 frame times with `tx_byte`=0x55 -> exactly one frame is sent and `tx` stays high afterwards.
- **Framing error:** send 0x3C with the stop bit held low -> `recv_error` pulses, no `received` pulse, and `rx_byte` is unchanged. After `rx` returns high, the next frame 0x81 is received correctly.
- **False start:** drive a 1000-cycle low glitch on `rx` -> no `received` and no `recv_error` pulse; `is_receiving` returns to 0.
- **Reset abort:** assert `rst` low mid-transmission -> `tx`=1 and `is_transmitting`=0 immediately; a subsequent 0x45 request transmits correctly.
